// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch with start/stop and clear keys, a programmable tick
// prescaler and a sticky overflow flag on the 9999 -> 0000 wrap.
module stopwatch_bcd #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start,
    input  logic       key_clear,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic       running,
    output logic       overflow
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [2:0]      start_sync;
    logic [2:0]      clear_sync;
    logic            start_pulse;
    logic            clear_pulse;
    logic [31:0]     prescaler;
    logic            tick;
    logic [3:0][3:0] digits;
    logic [3:0][3:0] digits_inc;
    logic            all_nines;

    // Bit 0 is the first flop; the pulse compares the 2nd and 3rd stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            clear_sync <= '0;
        end else begin
            start_sync <= {start_sync[1:0], key_start};
            clear_sync <= {clear_sync[1:0], key_clear};
        end
    end

    assign start_pulse = start_sync[1] & ~start_sync[2];
    assign clear_pulse = clear_sync[1] & ~clear_sync[2];
    assign tick        = (state == RUN) && (prescaler == PRESC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_pulse) begin
            state_next = STOP;
        end else if (start_pulse) begin
            state_next = (state == RUN) ? STOP : RUN;
        end
    end

    // Prescaler holds while stopped so a resumed run finishes the current period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (clear_pulse) begin
            prescaler <= '0;
        end else if (state == RUN) begin
            prescaler <= (prescaler == PRESC_MAX) ? '0 : prescaler + 32'd1;
        end
    end

    always_comb begin
        digits_inc = digits;
        all_nines  = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (all_nines) begin
                if (digits[i] == 4'd9) begin
                    digits_inc[i] = '0;
                end else begin
                    digits_inc[i] = digits[i] + 4'd1;
                    all_nines     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits   <= '0;
            overflow <= 1'b0;
        end else if (clear_pulse) begin
            digits   <= '0;
            overflow <= 1'b0;
        end else if (tick) begin
            digits <= digits_inc;
            if (all_nines) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out0    = digits[0];
    assign out1    = digits[1];
    assign out2    = digits[2];
    assign out3    = digits[3];
    assign running = (state == RUN);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: one instance with TICK_DIV=4, one with
// TICK_DIV=1; expectations are queued with the stimulus and popped when sampled.
module tb_stopwatch_bcd;

    logic       clk;
    logic       reset;
    logic       start4, clear4, start1, clear1;
    logic [3:0] d4_0, d4_1, d4_2, d4_3, d1_0, d1_1, d1_2, d1_3;
    logic       run4, ovf4, run1, ovf1;
    logic [17:0] v4, v1;

    stopwatch_bcd #(.TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .key_start(start4), .key_clear(clear4),
        .out0(d4_0), .out1(d4_1), .out2(d4_2), .out3(d4_3),
        .running(run4), .overflow(ovf4)
    );

    stopwatch_bcd #(.TICK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .key_start(start1), .key_clear(clear1),
        .out0(d1_0), .out1(d1_1), .out2(d1_2), .out3(d1_3),
        .running(run1), .overflow(ovf1)
    );

    assign v4 = {d4_3, d4_2, d4_1, d4_0, run4, ovf4};
    assign v1 = {d1_3, d1_2, d1_1, d1_0, run1, ovf1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    string       name_q[$];
    logic [17:0] val_q[$];
    bit          sel_q[$];
    string       e_name;
    logic [17:0] e_val;
    logic [17:0] obs;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic push_exp(input string name, input int n, input bit run, input bit ovf,
                            input bit sel);
        name_q.push_back(name);
        val_q.push_back({to_bcd(n), run, ovf});
        sel_q.push_back(sel);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        push_exp("reset_div4", 0, 0, 0, 0);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        push_exp("reset_div1", 0, 0, 0, 1);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_start;
        start4 = 1'b1;
        push_exp("start_edge2_still_stop", 0, 0, 0, 0);
        cyc(2);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        push_exp("start_edge3_run", 0, 1, 0, 0);
        cyc(1);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        start4 = 1'b0;
        push_exp("count_40_cycles", 10, 1, 0, 0);
        cyc(40);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
    endtask

    task automatic test_pause;
        // Each step: drive keys, queue expectation, wait, pop and compare.
        string nm[8]  = '{"pause_clear", "pause_start", "pause_run10", "pause_stop",
                          "pause_idle50", "pause_restart", "pause_not_full_yet",
                          "pause_resume_tick"};
        int    st[8]  = '{0, 1, 0, 1, 0, 1, 0, 0};
        int    cl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        int    wt[8]  = '{3, 3, 10, 3, 50, 3, 2, 1};
        int    cnt[8] = '{0, 0, 2, 3, 3, 3, 3, 4};
        int    rn[8]  = '{0, 1, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            start4 = st[i][0];
            clear4 = cl[i][0];
            push_exp(nm[i], cnt[i], rn[i][0], 1'b0, 0);
            cyc(wt[i]);
            e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
            total++;
            if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        end
        start4 = 1'b0;
        clear4 = 1'b0;
    endtask

    task automatic test_carry_wrap;
        string nm[6]  = '{"wrap_start", "ripple_0099", "ripple_0100", "at_9999",
                          "wrap_to_0000", "overflow_sticky"};
        int    st[6]  = '{1, 0, 0, 0, 0, 0};
        int    wt[6]  = '{3, 99, 1, 9899, 1, 5};
        int    cnt[6] = '{0, 99, 100, 9999, 0, 5};
        int    ov[6]  = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            start1 = st[i][0];
            push_exp(nm[i], cnt[i], 1'b1, ov[i][0], 1);
            cyc(wt[i]);
            e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
            total++;
            if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        end
        start1 = 1'b0;
    endtask

    task automatic test_clear_start;
        start1 = 1'b1;
        clear1 = 1'b1;
        push_exp("clear_start_coincide", 0, 0, 0, 1);
        cyc(3);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        start1 = 1'b0;
        clear1 = 1'b0;
        cyc(3);
        start1 = 1'b1;
        push_exp("held_one_toggle", 0, 1, 0, 1);
        cyc(3);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        push_exp("held_100_cycles", 100, 1, 0, 1);
        cyc(100);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        start1 = 1'b0;
        push_exp("held_release", 105, 1, 0, 1);
        cyc(5);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
    endtask

    task automatic test_start_tick;
        start1 = 1'b1;
        push_exp("start_with_tick", 108, 0, 0, 1);
        cyc(3);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        start1 = 1'b0;
        push_exp("stopped_holds", 108, 0, 0, 1);
        cyc(3);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        push_exp("async_reset_div4", 0, 0, 0, 0);
        push_exp("async_reset_div1", 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
            total++;
            if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        end
        @(negedge clk);
        reset = 1'b0;
        push_exp("after_release_stop", 0, 0, 0, 0);
        cyc(10);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
    endtask

    task automatic test_reset_held_key;
        start4 = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push_exp("held_key_no_pulse_yet", 0, 0, 0, 0);
        cyc(2);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        push_exp("held_key_pulse", 0, 1, 0, 0);
        cyc(1);
        e_name = name_q.pop_front(); e_val = val_q.pop_front(); obs = sel_q.pop_front() ? v1 : v4;
        total++;
        if (obs !== e_val) $display("FAIL %s: got %h expected %h", e_name, obs, e_val); else passed++;
        start4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        clear4 = 1'b0;
        start1 = 1'b0;
        clear1 = 1'b0;
        test_reset();
        test_start();
        test_pause();
        test_carry_wrap();
        test_clear_start();
        test_start_tick();
        test_async_reset();
        test_reset_held_key();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
